// File: rtl/mlp_batch_ctrl.sv
// Batch sequencer for the MLP datapath: fetches each sample, runs the MLP, takes a signed
// arg-max over its outputs and reports the prediction along with a running correct count.
module mlp_batch_ctrl #(
   parameter int NUM_FEATURES   = 4,
   parameter int NUM_CLASSES    = 3,
   parameter int FP_TOTAL_BITS  = 16,
   parameter int MAX_SAMPLES    = 64,
   parameter int LBL_W          = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ADDR_W        = $clog2(MAX_SAMPLES),
   localparam int CNT_W         = $clog2(MAX_SAMPLES + 1)
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    run,
   input  logic [CNT_W-1:0]                        num_samples,
   output logic [ADDR_W-1:0]                       smp_addr,
   input  logic [NUM_FEATURES*FP_TOTAL_BITS-1:0]   smp_x,
   input  logic [LBL_W-1:0]                        smp_label,
   output logic                                    mlp_reset,
   output logic                                    mlp_start,
   output logic [NUM_FEATURES*FP_TOTAL_BITS-1:0]   mlp_x,
   input  logic                                    mlp_done,
   input  logic [NUM_CLASSES*FP_TOTAL_BITS-1:0]    mlp_out,
   output logic                                    busy,
   output logic                                    pred_valid,
   output logic [ADDR_W-1:0]                       pred_idx,
   output logic [LBL_W-1:0]                        pred_class,
   output logic                                    pred_match,
   output logic [CNT_W-1:0]                        correct_cnt,
   output logic                                    batch_done,
   output logic                                    timeout_err,
   output logic [3:0]                              dbg_state
);

   localparam int CLS_W = $clog2(NUM_CLASSES);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

   // Handshake: run is accepted only in IDLE (busy low); mlp_start is a 1-cycle request and
   // completion is the first rising edge of mlp_done seen afterwards.
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LOAD, S_CLR, S_START, S_WAIT, S_ARGMAX, S_REPORT, S_DONE
   } state_t;

   state_t                            r_state;
   logic [CNT_W-1:0]                  r_n;
   logic [ADDR_W-1:0]                 r_idx;
   logic [LBL_W-1:0]                  r_lbl;
   logic                              r_done_prev;
   logic [WD_W-1:0]                   r_wd;
   logic signed [FP_TOTAL_BITS-1:0]   r_y [NUM_CLASSES];
   logic [CLS_W-1:0]                  r_best;
   logic [CLS_W-1:0]                  r_c;

   logic                              w_done_rise;
   logic [CNT_W-1:0]                  w_n_sat;
   logic                              w_last;
   logic                              w_match;

   assign w_done_rise = mlp_done & ~r_done_prev;
   assign w_n_sat     = (num_samples > CNT_W'(MAX_SAMPLES)) ? CNT_W'(MAX_SAMPLES) : num_samples;
   assign w_last      = (CNT_W'(r_idx) + CNT_W'(1)) == r_n;
   assign w_match     = LBL_W'(r_best) == r_lbl;
   assign dbg_state   = r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_idx       <= '0;
         r_lbl       <= '0;
         r_done_prev <= 1'b0;
         r_wd        <= '0;
         r_best      <= '0;
         r_c         <= '0;
         for (int c = 0; c < NUM_CLASSES; c++) r_y[c] <= '0;
         smp_addr    <= '0;
         mlp_reset   <= 1'b1;
         mlp_start   <= 1'b0;
         mlp_x       <= '0;
         busy        <= 1'b0;
         pred_valid  <= 1'b0;
         pred_idx    <= '0;
         pred_class  <= '0;
         pred_match  <= 1'b0;
         correct_cnt <= '0;
         batch_done  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         mlp_start   <= 1'b0;
         pred_valid  <= 1'b0;
         batch_done  <= 1'b0;
         r_done_prev <= mlp_done;
         case (r_state)
            S_IDLE: begin
               mlp_reset <= 1'b0;
               if (run) begin
                  busy        <= 1'b1;
                  correct_cnt <= '0;
                  timeout_err <= 1'b0;
                  r_n         <= w_n_sat;
                  r_idx       <= '0;
                  smp_addr    <= '0;
                  r_state     <= (w_n_sat == '0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH: r_state <= S_LOAD;
            // RAM data for smp_addr is valid here, one cycle after the address went out.
            S_LOAD: begin
               mlp_x     <= smp_x;
               r_lbl     <= smp_label;
               mlp_reset <= 1'b1;
               r_state   <= S_CLR;
            end
            S_CLR: begin
               mlp_reset <= 1'b0;
               mlp_start <= 1'b1;
               r_state   <= S_START;
            end
            S_START: begin
               r_wd    <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (w_done_rise) begin
                  for (int c = 0; c < NUM_CLASSES; c++)
                     r_y[c] <= mlp_out[c*FP_TOTAL_BITS +: FP_TOTAL_BITS];
                  r_best  <= '0;
                  r_c     <= CLS_W'(1);
                  r_state <= S_ARGMAX;
               end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_err <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_wd <= r_wd + WD_W'(1);
               end
            end
            // Strict greater-than keeps the lowest index on ties.
            S_ARGMAX: begin
               if (r_y[r_c] > r_y[r_best]) r_best <= r_c;
               if (r_c == CLS_W'(NUM_CLASSES - 1)) r_state <= S_REPORT;
               else r_c <= r_c + CLS_W'(1);
            end
            S_REPORT: begin
               pred_valid <= 1'b1;
               pred_idx   <= r_idx;
               pred_class <= LBL_W'(r_best);
               pred_match <= w_match;
               if (w_match) correct_cnt <= correct_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx    <= r_idx + ADDR_W'(1);
                  smp_addr <= r_idx + ADDR_W'(1);
                  r_state  <= S_FETCH;
               end
            end
            S_DONE: begin
               batch_done <= 1'b1;
               busy       <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_batch_ctrl.sv
// Directed bench for mlp_batch_ctrl with a behavioural sample RAM and MLP model.
module tb_mlp_batch_ctrl;

   localparam int NF = 4, NC = 3, FP = 16, MS = 64, LW = 8, TO = 16;
   localparam int AW = 6, CW = 7;

   logic              clk = 1'b0;
   logic              reset;
   logic              run;
   logic [CW-1:0]     num_samples;
   logic [AW-1:0]     smp_addr;
   logic [NF*FP-1:0]  smp_x;
   logic [LW-1:0]     smp_label;
   logic              mlp_reset, mlp_start, mlp_done;
   logic [NF*FP-1:0]  mlp_x;
   logic [NC*FP-1:0]  mlp_out;
   logic              busy, pred_valid, pred_match, batch_done, timeout_err;
   logic [AW-1:0]     pred_idx;
   logic [LW-1:0]     pred_class;
   logic [CW-1:0]     correct_cnt;
   logic [3:0]        dbg_state;

   int total = 0;
   int bad   = 0;

   mlp_batch_ctrl #(
      .NUM_FEATURES(NF), .NUM_CLASSES(NC), .FP_TOTAL_BITS(FP),
      .MAX_SAMPLES(MS), .LBL_W(LW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .num_samples(num_samples),
      .smp_addr(smp_addr), .smp_x(smp_x), .smp_label(smp_label),
      .mlp_reset(mlp_reset), .mlp_start(mlp_start), .mlp_x(mlp_x),
      .mlp_done(mlp_done), .mlp_out(mlp_out), .busy(busy),
      .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_class(pred_class),
      .pred_match(pred_match), .correct_cnt(correct_cnt), .batch_done(batch_done),
      .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- sample RAM model (1-cycle read latency) ----------------
   logic [LW-1:0] lbl_mem [MS];

   function automatic logic [NF*FP-1:0] x_of(input int i);
      logic [NF*FP-1:0] v;
      for (int f = 0; f < NF; f++) v[f*FP +: FP] = {i[7:0], 8'(f + 1)};
      return v;
   endfunction

   always @(posedge clk) begin
      smp_x     <= x_of(int'(smp_addr));
      smp_label <= lbl_mem[smp_addr];
   end

   // ---------------- MLP model ----------------
   logic [FP-1:0] y0, y1, y2;
   int            m_lat;
   logic          m_hang;
   logic          m_arm;
   int            m_cnt;

   assign mlp_out = {y2, y1, y0};

   always @(posedge clk) begin
      if (mlp_reset) begin
         mlp_done <= 1'b0;
         m_arm    <= 1'b0;
         m_cnt    <= 0;
      end else if (mlp_start) begin
         m_arm <= 1'b1;
         m_cnt <= 0;
      end else if (m_arm && !m_hang) begin
         if (m_cnt == m_lat - 1) begin
            mlp_done <= 1'b1;
            m_arm    <= 1'b0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   // ---------------- batch collector ----------------
   logic [LW-1:0] got_class [$];
   logic          got_match [$];
   logic [AW-1:0] got_idx   [$];
   int            starts, x_err, start_cyc, done_lat, done_pulses;
   logic          done_busy, done_to;
   logic [CW-1:0] done_cnt;

   task automatic run_batch(input logic [CW-1:0] ns, input int budget, input int extra_run_cyc);
      got_class.delete(); got_match.delete(); got_idx.delete();
      starts = 0; x_err = 0; start_cyc = -1; done_lat = -1; done_pulses = 0;
      done_busy = 1'bx; done_to = 1'bx; done_cnt = 'x;
      @(negedge clk);
      num_samples = ns;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (mlp_start) begin
            if (start_cyc < 0) start_cyc = cyc;
            if (mlp_x !== x_of(starts)) x_err++;
            starts++;
         end
         if (pred_valid) begin
            got_class.push_back(pred_class);
            got_match.push_back(pred_match);
            got_idx.push_back(pred_idx);
         end
         if (batch_done) begin
            done_lat = cyc; done_pulses++;
            done_busy = busy; done_to = timeout_err; done_cnt = correct_cnt;
            break;
         end
         run = (cyc == extra_run_cyc);
         @(negedge clk);
      end
      run = 1'b0;
   endtask

   task automatic set_y(input logic [FP-1:0] a, input logic [FP-1:0] b, input logic [FP-1:0] c);
      y0 = a; y1 = b; y2 = c;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({mlp_reset, mlp_start, busy, pred_valid, pred_match, batch_done, timeout_err} !== 7'b1000000) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=1000000",
                  {mlp_reset, mlp_start, busy, pred_valid, pred_match, batch_done, timeout_err});
      end
      total++;
      if ({smp_addr, pred_idx, pred_class, correct_cnt} !== '0 || mlp_x !== '0) begin
         bad++;
         $display("FAIL reset_data addr=%0d idx=%0d cls=%0d cnt=%0d x=%h want all 0",
                  smp_addr, pred_idx, pred_class, correct_cnt, mlp_x);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (mlp_reset !== 1'b0) begin
         bad++; $display("FAIL idle_mlp_reset got=%b want=0", mlp_reset);
      end
   endtask

   task automatic test_basic;
      logic [LW-1:0] ec [3] = '{8'd1, 8'd1, 8'd1};
      logic          em [3] = '{1'b1, 1'b1, 1'b0};
      lbl_mem[0] = 8'd1; lbl_mem[1] = 8'd1; lbl_mem[2] = 8'd0;
      set_y(16'h0100, 16'h0300, 16'h0200);
      run_batch(7'd3, 200, 0);
      total++;
      if (got_class.size() != 3) begin
         bad++; $display("FAIL basic_npred got=%0d want=3", got_class.size());
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (got_class.size() <= i || got_class[i] !== ec[i] || got_match[i] !== em[i] || got_idx[i] !== AW'(i)) begin
            bad++;
            $display("FAIL basic_pred%0d got cls=%0d match=%b idx=%0d want cls=%0d match=%b idx=%0d", i,
                     (got_class.size() > i) ? got_class[i] : 8'hxx,
                     (got_match.size() > i) ? got_match[i] : 1'bx,
                     (got_idx.size() > i) ? got_idx[i] : 6'hxx, ec[i], em[i], i);
         end
      end
      total++;
      if (done_cnt !== 7'd2 || done_pulses != 1 || done_busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_done cnt=%0d pulses=%0d busy=%b want cnt=2 pulses=1 busy=0",
                  done_cnt, done_pulses, done_busy);
      end
      total++;
      if (x_err != 0 || starts != 3) begin
         bad++; $display("FAIL basic_mlp_x errs=%0d starts=%0d want errs=0 starts=3", x_err, starts);
      end
      repeat (3) @(negedge clk);
      total++;
      if (pred_class !== 8'd1 || pred_idx !== 6'd2 || pred_match !== 1'b0 || batch_done !== 1'b0) begin
         bad++;
         $display("FAIL basic_hold cls=%0d idx=%0d match=%b bd=%b want 1 2 0 0",
                  pred_class, pred_idx, pred_match, batch_done);
      end
   endtask

   task automatic test_tie;
      lbl_mem[0] = 8'd0;
      set_y(16'h0080, 16'h0080, 16'h0080);
      run_batch(7'd1, 100, 0);
      total++;
      if (got_class.size() != 1 || got_class[0] !== 8'd0 || got_match[0] !== 1'b1 || done_cnt !== 7'd1) begin
         bad++;
         $display("FAIL tie_lowest n=%0d cls=%0d cnt=%0d want n=1 cls=0 cnt=1", got_class.size(),
                  (got_class.size() > 0) ? got_class[0] : 8'hxx, done_cnt);
      end
   endtask

   task automatic test_signed;
      lbl_mem[0] = 8'd2;
      set_y(16'hFE00, 16'hFF00, 16'hFD00);
      run_batch(7'd1, 100, 0);
      total++;
      if (got_class.size() != 1 || got_class[0] !== 8'd1 || got_match[0] !== 1'b0 || done_cnt !== 7'd0) begin
         bad++;
         $display("FAIL signed_cmp n=%0d cls=%0d cnt=%0d want n=1 cls=1 cnt=0", got_class.size(),
                  (got_class.size() > 0) ? got_class[0] : 8'hxx, done_cnt);
      end
   endtask

   task automatic test_zero;
      run_batch(7'd0, 20, 0);
      total++;
      if (done_lat != 2 || starts != 0 || done_cnt !== 7'd0 || got_class.size() != 0) begin
         bad++;
         $display("FAIL zero_batch lat=%0d starts=%0d cnt=%0d preds=%0d want lat=2 starts=0 cnt=0 preds=0",
                  done_lat, starts, done_cnt, got_class.size());
      end
   endtask

   task automatic test_timeout;
      m_hang = 1'b1;
      run_batch(7'd2, 100, 0);
      // 16 WAIT cycles, then DONE, then the registered batch_done pulse.
      total++;
      if (done_lat < 0 || start_cyc < 0 || done_lat - start_cyc != 18) begin
         bad++;
         $display("FAIL timeout_lat start=%0d done=%0d want done-start=18", start_cyc, done_lat);
      end
      total++;
      if (done_to !== 1'b1 || got_class.size() != 0 || starts != 1) begin
         bad++;
         $display("FAIL timeout_err err=%b preds=%0d starts=%0d want err=1 preds=0 starts=1",
                  done_to, got_class.size(), starts);
      end
      repeat (4) @(negedge clk);
      total++;
      if (timeout_err !== 1'b1) begin
         bad++; $display("FAIL timeout_sticky got=%b want=1", timeout_err);
      end
      m_hang = 1'b0;
      lbl_mem[0] = 8'd2;
      set_y(16'h0010, 16'h0020, 16'h0030);
      run_batch(7'd1, 100, 0);
      total++;
      if (timeout_err !== 1'b0 || got_class.size() != 1 || done_cnt !== 7'd1) begin
         bad++;
         $display("FAIL timeout_clear err=%b preds=%0d cnt=%0d want err=0 preds=1 cnt=1",
                  timeout_err, got_class.size(), done_cnt);
      end
   endtask

   task automatic test_reset_in_wait;
      int guard;
      m_lat = 10;
      @(negedge clk);
      num_samples = 7'd2;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      guard = 0;
      while (!mlp_start && guard < 20) begin
         @(negedge clk); guard++;
      end
      repeat (3) @(negedge clk);
      total++;
      if (dbg_state !== 4'd5 || busy !== 1'b1) begin
         bad++; $display("FAIL rst_wait_pre state=%0d busy=%b want state=5 busy=1", dbg_state, busy);
      end
      reset = 1'b1;
      #1;
      total++;
      if (mlp_reset !== 1'b1 || busy !== 1'b0 || mlp_x !== '0 || dbg_state !== 4'd0 || mlp_start !== 1'b0) begin
         bad++;
         $display("FAIL rst_wait_async mlp_reset=%b busy=%b x=%h state=%0d want 1 0 0 0",
                  mlp_reset, busy, mlp_x, dbg_state);
      end
      @(negedge clk);
      reset = 1'b0;
      m_lat = 3;
      lbl_mem[0] = 8'd1; lbl_mem[1] = 8'd0;
      set_y(16'h0100, 16'h0300, 16'h0200);
      run_batch(7'd2, 200, 0);
      total++;
      if (got_class.size() != 2 || got_class[0] !== 8'd1 || got_class[1] !== 8'd1 ||
          got_match[0] !== 1'b1 || got_match[1] !== 1'b0 || done_cnt !== 7'd1) begin
         bad++;
         $display("FAIL rst_wait_rerun preds=%0d cnt=%0d want preds=2 cls=1,1 match=1,0 cnt=1",
                  got_class.size(), done_cnt);
      end
   endtask

   task automatic test_back_to_back;
      int idx_err;
      for (int i = 0; i < MS; i++) lbl_mem[i] = 8'(i % 3);
      set_y(16'h0010, 16'h0020, 16'h0030);
      run_batch(7'd100, 3000, 50);
      total++;
      if (got_class.size() != 64 || starts != 64 || done_pulses != 1) begin
         bad++;
         $display("FAIL b2b_count preds=%0d starts=%0d pulses=%0d want 64 64 1",
                  got_class.size(), starts, done_pulses);
      end
      idx_err = 0;
      foreach (got_idx[i]) if (got_idx[i] !== AW'(i) || got_class[i] !== 8'd2) idx_err++;
      total++;
      if (idx_err != 0 || x_err != 0) begin
         bad++; $display("FAIL b2b_order idx_errs=%0d x_errs=%0d want 0 0", idx_err, x_err);
      end
      total++;
      if (done_cnt !== 7'd21) begin
         bad++; $display("FAIL b2b_correct got=%0d want=21", done_cnt);
      end
      run_batch(7'd2, 200, 0);
      total++;
      if (got_class.size() != 2 || done_cnt !== 7'd0 || got_idx[1] !== 6'd1) begin
         bad++;
         $display("FAIL b2b_second preds=%0d cnt=%0d want preds=2 cnt=0", got_class.size(), done_cnt);
      end
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0 || dbg_state !== 4'd0) begin
         bad++; $display("FAIL b2b_idle busy=%b state=%0d want 0 0", busy, dbg_state);
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; num_samples = '0;
      m_lat = 3; m_hang = 1'b0;
      set_y('0, '0, '0);
      for (int i = 0; i < MS; i++) lbl_mem[i] = '0;
      test_reset();
      test_basic();
      test_tie();
      test_signed();
      test_zero();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
